// File: rtl/median_filter_3x3_8bit_pkg.sv
// Shared image-processing constants for the 3x3 median filter slice.
package median_filter_3x3_8bit_pkg;

    localparam int unsigned PIPE_LATENCY = 3;
    localparam int unsigned PIX_W        = 8;

endpackage

// File: rtl/median_filter_3x3_8bit_sort3.sv
// Combinational 3-input unsigned sorter: max / mid / min.
module sort3_8bit
    import median_filter_3x3_8bit_pkg::*;
(
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] c,
    output logic [PIX_W-1:0] max_val,
    output logic [PIX_W-1:0] mid_val,
    output logic [PIX_W-1:0] min_val
);

    logic [PIX_W-1:0] hi_s;
    logic [PIX_W-1:0] lo_s;

    // order the first pair
    always_comb begin
        hi_s = a;
        lo_s = b;
        if (a >= b) begin
            hi_s = a;
            lo_s = b;
        end else begin
            hi_s = b;
            lo_s = a;
        end
    end

    // slot the third value into the ordered pair; ties fall through to the lower branch
    always_comb begin
        max_val = hi_s;
        mid_val = lo_s;
        min_val = lo_s;
        if (c > hi_s) begin
            max_val = c;
            mid_val = hi_s;
            min_val = lo_s;
        end else if (c > lo_s) begin
            max_val = hi_s;
            mid_val = c;
            min_val = lo_s;
        end else begin
            max_val = hi_s;
            mid_val = lo_s;
            min_val = c;
        end
    end

endmodule

// File: rtl/median_filter_3x3_8bit.sv
// 3x3 median filter: row sort, cross-row min/med/max, final median; 3-cycle pipeline.
module median_filter_3x3_8bit
    import median_filter_3x3_8bit_pkg::*;
#(
    parameter bit EDGE_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             matrix_img_vsync,
    input  logic             matrix_img_href,
    input  logic             matrix_top_edge_flag,
    input  logic             matrix_bottom_edge_flag,
    input  logic             matrix_left_edge_flag,
    input  logic             matrix_right_edge_flag,
    input  logic [PIX_W-1:0] matrix_p11,
    input  logic [PIX_W-1:0] matrix_p12,
    input  logic [PIX_W-1:0] matrix_p13,
    input  logic [PIX_W-1:0] matrix_p21,
    input  logic [PIX_W-1:0] matrix_p22,
    input  logic [PIX_W-1:0] matrix_p23,
    input  logic [PIX_W-1:0] matrix_p31,
    input  logic [PIX_W-1:0] matrix_p32,
    input  logic [PIX_W-1:0] matrix_p33,
    output logic             post_img_vsync,
    output logic             post_img_href,
    output logic [PIX_W-1:0] post_img_gray
);

    logic [PIX_W-1:0] row_a_s [3];
    logic [PIX_W-1:0] row_b_s [3];
    logic [PIX_W-1:0] row_c_s [3];
    logic [PIX_W-1:0] s1_max_s [3];
    logic [PIX_W-1:0] s1_mid_s [3];
    logic [PIX_W-1:0] s1_min_s [3];
    logic [PIX_W-1:0] s1_max_r [3];
    logic [PIX_W-1:0] s1_mid_r [3];
    logic [PIX_W-1:0] s1_min_r [3];

    logic [PIX_W-1:0] s2_lo_s, s2_med_s, s2_hi_s;
    logic [PIX_W-1:0] s2_lo_r, s2_med_r, s2_hi_r;
    logic [PIX_W-1:0] s2a_max_unused_s, s2a_mid_unused_s;
    logic [PIX_W-1:0] s2b_max_unused_s, s2b_min_unused_s;
    logic [PIX_W-1:0] s2c_mid_unused_s, s2c_min_unused_s;
    logic [PIX_W-1:0] s3_max_unused_s, s3_min_unused_s;
    logic [PIX_W-1:0] s3_med_s;

    logic [PIPE_LATENCY-1:0] vsync_d_r;
    logic [PIPE_LATENCY-1:0] href_d_r;
    logic                    border_s;
    logic [1:0]              border_d_r;
    logic [PIX_W-1:0]        p22_d_r [2];
    logic [PIX_W-1:0]        gray_nxt_s;
    logic [PIX_W-1:0]        gray_r;

    assign row_a_s[0] = matrix_p11;
    assign row_b_s[0] = matrix_p12;
    assign row_c_s[0] = matrix_p13;
    assign row_a_s[1] = matrix_p21;
    assign row_b_s[1] = matrix_p22;
    assign row_c_s[1] = matrix_p23;
    assign row_a_s[2] = matrix_p31;
    assign row_b_s[2] = matrix_p32;
    assign row_c_s[2] = matrix_p33;

    for (genvar r = 0; r < 3; r++) begin : g_row_sort
        sort3_8bit u_row_sort (
            .a       (row_a_s[r]),
            .b       (row_b_s[r]),
            .c       (row_c_s[r]),
            .max_val (s1_max_s[r]),
            .mid_val (s1_mid_s[r]),
            .min_val (s1_min_s[r])
        );
    end

    // stage 1: per-row sorted triples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                s1_max_r[i] <= 8'h00;
                s1_mid_r[i] <= 8'h00;
                s1_min_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                s1_max_r[i] <= s1_max_s[i];
                s1_mid_r[i] <= s1_mid_s[i];
                s1_min_r[i] <= s1_min_s[i];
            end
        end
    end

    // only one output of each cross-row sorter is needed
    sort3_8bit u_max_col (
        .a       (s1_max_r[0]),
        .b       (s1_max_r[1]),
        .c       (s1_max_r[2]),
        .max_val (s2a_max_unused_s),
        .mid_val (s2a_mid_unused_s),
        .min_val (s2_lo_s)
    );

    sort3_8bit u_mid_col (
        .a       (s1_mid_r[0]),
        .b       (s1_mid_r[1]),
        .c       (s1_mid_r[2]),
        .max_val (s2b_max_unused_s),
        .mid_val (s2_med_s),
        .min_val (s2b_min_unused_s)
    );

    sort3_8bit u_min_col (
        .a       (s1_min_r[0]),
        .b       (s1_min_r[1]),
        .c       (s1_min_r[2]),
        .max_val (s2_hi_s),
        .mid_val (s2c_mid_unused_s),
        .min_val (s2c_min_unused_s)
    );

    // stage 2: the three median candidates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_lo_r  <= 8'h00;
            s2_med_r <= 8'h00;
            s2_hi_r  <= 8'h00;
        end else begin
            s2_lo_r  <= s2_lo_s;
            s2_med_r <= s2_med_s;
            s2_hi_r  <= s2_hi_s;
        end
    end

    sort3_8bit u_final (
        .a       (s2_lo_r),
        .b       (s2_med_r),
        .c       (s2_hi_r),
        .max_val (s3_max_unused_s),
        .mid_val (s3_med_s),
        .min_val (s3_min_unused_s)
    );

    assign border_s = (matrix_top_edge_flag | matrix_bottom_edge_flag |
                       matrix_left_edge_flag | matrix_right_edge_flag) & matrix_img_href;

    // sync, border and centre-pixel delay lines kept in step with the data stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_r  <= '0;
            href_d_r   <= '0;
            border_d_r <= 2'b00;
            p22_d_r[0] <= 8'h00;
            p22_d_r[1] <= 8'h00;
        end else begin
            vsync_d_r  <= {vsync_d_r[PIPE_LATENCY-2:0], matrix_img_vsync};
            href_d_r   <= {href_d_r[PIPE_LATENCY-2:0], matrix_img_href};
            border_d_r <= {border_d_r[0], border_s};
            p22_d_r[0] <= matrix_p22;
            p22_d_r[1] <= p22_d_r[0];
        end
    end

    // output selection: blank when idle, centre on bypassed borders, else median
    always_comb begin
        gray_nxt_s = 8'h00;
        if (!href_d_r[1]) begin
            gray_nxt_s = 8'h00;
        end else if ((EDGE_BYPASS == 1'b1) && border_d_r[1]) begin
            gray_nxt_s = p22_d_r[1];
        end else begin
            gray_nxt_s = s3_med_s;
        end
    end

    // stage 3: registered median / output pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_r <= 8'h00;
        end else begin
            gray_r <= gray_nxt_s;
        end
    end

    assign post_img_vsync = vsync_d_r[PIPE_LATENCY-1];
    assign post_img_href  = href_d_r[PIPE_LATENCY-1];
    assign post_img_gray  = gray_r;

endmodule

// File: tb/tb_median_filter_3x3_8bit.sv
// Directed bench: two instances (edge bypass on / off) driven by shared window vectors.
module tb_median_filter_3x3_8bit;

    typedef struct packed {
        logic        vs;
        logic        hr;
        logic [3:0]  edg;   // {top, bottom, left, right}
        logic [71:0] win;   // p11 in the top byte ... p33 in the bottom byte
        logic [7:0]  exp1;  // expected gray, EDGE_BYPASS=1
        logic [7:0]  exp0;  // expected gray, EDGE_BYPASS=0
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync, href, top_f, bot_f, left_f, right_f;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic       byp_vsync, byp_href, med_vsync, med_href;
    logic [7:0] byp_gray, med_gray;

    int   total = 0;
    int   bad = 0;
    vec_t seq [$];

    always #5 clk = ~clk;

    median_filter_3x3_8bit #(.EDGE_BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n),
        .matrix_img_vsync(vsync), .matrix_img_href(href),
        .matrix_top_edge_flag(top_f), .matrix_bottom_edge_flag(bot_f),
        .matrix_left_edge_flag(left_f), .matrix_right_edge_flag(right_f),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
        .post_img_vsync(byp_vsync), .post_img_href(byp_href), .post_img_gray(byp_gray)
    );

    median_filter_3x3_8bit #(.EDGE_BYPASS(1'b0)) dut_med (
        .clk(clk), .rst_n(rst_n),
        .matrix_img_vsync(vsync), .matrix_img_href(href),
        .matrix_top_edge_flag(top_f), .matrix_bottom_edge_flag(bot_f),
        .matrix_left_edge_flag(left_f), .matrix_right_edge_flag(right_f),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
        .post_img_vsync(med_vsync), .post_img_href(med_href), .post_img_gray(med_gray)
    );

    function automatic vec_t mk(input logic vs, input logic hr, input logic [3:0] edg,
                                input logic [71:0] win, input logic [7:0] e1,
                                input logic [7:0] e0);
        vec_t v;
        v.vs = vs; v.hr = hr; v.edg = edg; v.win = win; v.exp1 = e1; v.exp0 = e0;
        return v;
    endfunction

    task automatic drive_vec(input vec_t v);
        vsync = v.vs;
        href  = v.hr;
        {top_f, bot_f, left_f, right_f} = v.edg;
        {p11, p12, p13, p21, p22, p23, p31, p32, p33} = v.win;
    endtask

    // idle cycle carrying junk window data and all border flags
    function automatic vec_t idle_vec();
        return mk(1'b0, 1'b0, 4'hf, {9{8'hff}}, 8'h00, 8'h00);
    endfunction

    task automatic test_reset();
        drive_vec(mk(1'b1, 1'b1, 4'h0, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60,
                                       8'd70, 8'd80, 8'd90}, 8'd50, 8'd50));
        repeat (4) @(negedge clk);
        if ({byp_vsync, byp_href, med_vsync, med_href} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_sync: got %b%b%b%b want 0000", byp_vsync, byp_href,
                     med_vsync, med_href);
        end
        total++;
        if (byp_gray !== 8'h00) begin
            bad++;
            $display("FAIL reset_gray_byp: got %0d want 0", byp_gray);
        end
        total++;
        if (med_gray !== 8'h00) begin
            bad++;
            $display("FAIL reset_gray_med: got %0d want 0", med_gray);
        end
        total++;
        drive_vec(idle_vec());
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // streams seq one vector per cycle; output for vector k is checked at negedge k+3
    task automatic test_stream(input string name);
        vec_t e;
        for (int k = 0; k < seq.size() + 3; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                e = seq[k-3];
                if (byp_href !== e.hr || med_href !== e.hr) begin
                    bad++;
                    $display("FAIL %s href[%0d]: got %b/%b want %b", name, k-3,
                             byp_href, med_href, e.hr);
                end
                total++;
                if (byp_vsync !== e.vs || med_vsync !== e.vs) begin
                    bad++;
                    $display("FAIL %s vsync[%0d]: got %b/%b want %b", name, k-3,
                             byp_vsync, med_vsync, e.vs);
                end
                total++;
                if (byp_gray !== e.exp1) begin
                    bad++;
                    $display("FAIL %s gray_byp[%0d]: got %0d want %0d", name, k-3,
                             byp_gray, e.exp1);
                end
                total++;
                if (med_gray !== e.exp0) begin
                    bad++;
                    $display("FAIL %s gray_med[%0d]: got %0d want %0d", name, k-3,
                             med_gray, e.exp0);
                end
                total++;
            end
            if (k < seq.size()) drive_vec(seq[k]);
            else drive_vec(idle_vec());
        end
    endtask

    task automatic test_ramp();
        seq = {};
        seq.push_back(mk(1'b1, 1'b1, 4'h0, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60,
                                           8'd70, 8'd80, 8'd90}, 8'd50, 8'd50));
        test_stream("ramp");
    endtask

    task automatic test_impulse();
        seq = {};
        seq.push_back(mk(1'b1, 1'b1, 4'h0, {{4{8'd0}}, 8'd255, {4{8'd0}}}, 8'd0, 8'd0));
        seq.push_back(mk(1'b1, 1'b1, 4'h0, {{4{8'd255}}, 8'd0, {4{8'd255}}}, 8'd255, 8'd255));
        test_stream("impulse");
    endtask

    task automatic test_ties_unsigned();
        seq = {};
        seq.push_back(mk(1'b1, 1'b1, 4'h0, {8'd5, 8'd5, 8'd5, 8'd5, 8'd9, 8'd1,
                                           8'd5, 8'd5, 8'd2}, 8'd5, 8'd5));
        seq.push_back(mk(1'b1, 1'b1, 4'h0, {8'd3, 8'd3, 8'd9, 8'd9, 8'd9, 8'd3,
                                           8'd3, 8'd9, 8'd3}, 8'd3, 8'd3));
        seq.push_back(mk(1'b1, 1'b1, 4'h0, {9{8'd77}}, 8'd77, 8'd77));
        seq.push_back(mk(1'b1, 1'b1, 4'h0, {8'd200, 8'd1, 8'd100, 8'd50, 8'd150, 8'd25,
                                           8'd250, 8'd75, 8'd125}, 8'd100, 8'd100));
        seq.push_back(mk(1'b1, 1'b1, 4'h0, {8'd128, 8'd127, 8'd129, 8'd0, 8'd255, 8'd130,
                                           8'd126, 8'd131, 8'd1}, 8'd128, 8'd128));
        test_stream("ties");
    endtask

    task automatic test_edges();
        seq = {};
        seq.push_back(mk(1'b1, 1'b1, 4'b0010, {{4{8'd7}}, 8'd200, {4{8'd7}}}, 8'd200, 8'd7));
        seq.push_back(mk(1'b1, 1'b1, 4'b1000, {{4{8'd9}}, 8'd33, {4{8'd9}}}, 8'd33, 8'd9));
        seq.push_back(mk(1'b1, 1'b1, 4'b0100, {{4{8'd4}}, 8'd99, {4{8'd4}}}, 8'd99, 8'd4));
        seq.push_back(mk(1'b1, 1'b1, 4'b0001, {{4{8'd2}}, 8'd66, {4{8'd2}}}, 8'd66, 8'd2));
        seq.push_back(mk(1'b1, 1'b1, 4'b0000, {{4{8'd7}}, 8'd200, {4{8'd7}}}, 8'd7, 8'd7));
        test_stream("edges");
    endtask

    task automatic test_back_to_back();
        seq = {};
        seq.push_back(mk(1'b1, 1'b1, 4'h0, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60,
                                           8'd70, 8'd80, 8'd90}, 8'd50, 8'd50));
        seq.push_back(mk(1'b1, 1'b1, 4'b0001, {8'd1, 8'd2, 8'd3, 8'd4, 8'd60, 8'd6,
                                              8'd7, 8'd8, 8'd9}, 8'd60, 8'd6));
        seq.push_back(idle_vec());
        seq.push_back(mk(1'b1, 1'b1, 4'h0, {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4,
                                           8'd3, 8'd2, 8'd1}, 8'd5, 8'd5));
        seq.push_back(mk(1'b1, 1'b1, 4'b1000, {{4{8'd255}}, 8'd0, {4{8'd255}}}, 8'd0, 8'd255));
        seq.push_back(mk(1'b0, 1'b1, 4'h0, {8'd200, 8'd1, 8'd100, 8'd50, 8'd150, 8'd25,
                                           8'd250, 8'd75, 8'd125}, 8'd100, 8'd100));
        seq.push_back(idle_vec());
        test_stream("b2b");
    endtask

    task automatic test_mid_reset();
        logic want_hr;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_vec(mk(1'b1, 1'b1, 4'h0, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60,
                                           8'd70, 8'd80, 8'd90}, 8'd50, 8'd50));
        end
        @(posedge clk);
        #2;
        if (byp_gray !== 8'd50 || byp_href !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_pixel: got href=%b gray=%0d want href=1 gray=50",
                     byp_href, byp_gray);
        end
        total++;
        rst_n = 1'b0;
        #1;
        if ({byp_vsync, byp_href, byp_gray, med_vsync, med_href, med_gray} !== 20'h0) begin
            bad++;
            $display("FAIL async_reset: got %b %b %0d / %b %b %0d want all 0", byp_vsync,
                     byp_href, byp_gray, med_vsync, med_href, med_gray);
        end
        total++;
        drive_vec(idle_vec());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            want_hr = (k == 6);
            if (byp_href !== want_hr || med_vsync !== want_hr ||
                byp_gray !== (want_hr ? 8'd50 : 8'd0)) begin
                bad++;
                $display("FAIL post_reset[%0d]: got href=%b vsync=%b gray=%0d want href=%b",
                         k, byp_href, med_vsync, byp_gray, want_hr);
            end
            total++;
            if (k == 3)
                drive_vec(mk(1'b1, 1'b1, 4'h0, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60,
                                               8'd70, 8'd80, 8'd90}, 8'd50, 8'd50));
            else
                drive_vec(idle_vec());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        drive_vec(idle_vec());
        test_reset();
        test_ramp();
        test_impulse();
        test_ties_unsigned();
        test_edges();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
